gardner_symbol_sync_ctrl: RTL
=============================

// Module: gardner_symbol_sync_ctrl
// PURPOSE
//  Symbol-timing loop controller for the 32x-oversampled Gardner timing error detector (TED).
//  Counts samples to produce the per-symbol strobe at which the TED output is taken.
//  Filters the TED error with a PI loop and slips the sample counter by +/-1 sample to
//  track symbol phase. Reports loop lock. Sits between the RRC/matched-filter sample
//  stream and the symbol decision/demap stage.
// PARAMETERS
//  WIDTH     16    TED error width (signed)
//  OSR       32    samples per symbol; OSR >= 8
//  ACC_W     24    integrator / phase accumulator width (signed), ACC_W > WIDTH
//  KP_SHIFT  2     proportional gain = err >>> KP_SHIFT
//  KI_SHIFT  6     integral gain = integ >>> KI_SHIFT
//  THRESH    4096  phase accumulator magnitude that triggers a one-sample slip
//  LOCK_TOL  512   |err| < LOCK_TOL counts as a good symbol
//  LOCK_CNT  64    consecutive good symbols required to assert locked
// PORTS
//  clk          in   1        single system clock
//  rst          in   1        synchronous, active-high reset
//  enable       in   1        loop run; 0 = hold in IDLE
//  sample_valid in   1        one new oversampled sample this cycle
//  err_in       in   WIDTH    TED error_n (registered in TED; valid 1 cycle after strobe)
//  sym_strobe   out  1        symbol-midpoint pulse, 1 cycle, coincident with sample_valid
//  phase        out  log2(OSR) current sample counter value
//  slip_adv     out  1        1-cycle pulse: counter skipped one sample (0 -> 2)
//  slip_ret     out  1        1-cycle pulse: counter held one extra sample at 0
//  locked       out  1        loop lock indicator
//  integ        out  ACC_W    integrator value (debug)
// BEHAVIOUR
//  Reset: all outputs 0; cnt=0, integ=0, pacc=0, pending slip=none, lock count=0, FSM=IDLE.
//  Counter: on sample_valid, cnt <= (cnt==OSR-1) ? 0 : cnt+1, except at cnt==0:
//   - pending advance -> cnt <= 2, slip_adv pulses, pending cleared.
//   - pending retard  -> cnt stays 0 one extra sample, slip_ret pulses, pending cleared.
//   Counter advances in every FSM state except IDLE (held at 0).
//  sym_strobe = sample_valid && cnt==OSR-1 && FSM!=IDLE (combinational from the registered cnt).
//  FSM: IDLE -> TRACK when enable. TRACK -> CAPTURE on sym_strobe.
//   CAPTURE (1 clk): err_r <= err_in.
//   FILTER (1 clk): integ <= sat(integ + err_r);
//    pacc <= sat(pacc + (err_r>>>KP_SHIFT) + (integ>>>KI_SHIFT)), using the old integ.
//   ADJUST (1 clk): pacc >= THRESH -> pending=retard, pacc -= THRESH;
//    pacc <= -THRESH -> pending=advance, pacc += THRESH; else no change. Then -> TRACK.
//   A slip already pending is not overwritten; the new one waits for the next symbol.
//  Sign convention: positive filtered error means sampling is early and causes a retard.
//  Saturation: integ and pacc clamp to [-(2^(ACC_W-1)-1), 2^(ACC_W-1)-1]; no wrap.
//  Lock: evaluated in FILTER. |err_r| < LOCK_TOL -> good count +1, saturating at LOCK_CNT.
//   Otherwise good count = 0 and locked = 0. locked = 1 when good count == LOCK_CNT.
//  enable=0 in any state -> IDLE next cycle; clears integ, pacc, pending, lock, cnt.
//   The FSM never ends mid-symbol with stale state.
//  CAPTURE..ADJUST takes 3 cycles, which is < OSR samples, so they never overlap the next strobe.
//  sample_valid may be asserted every cycle.
// TESTING
//  1. rst=1 for 2 clk with enable=1 -> all outputs 0.
//     Release: first sym_strobe on the 32nd sample_valid, then every 32.
//  2. err_in=0 constant, 200 symbols -> no slip pulses, integ=0, locked=1 after the 64th strobe.
//  3. err_in=+2000 constant -> integ +2000 per symbol; slip_ret pulses and the strobe interval
//     becomes 33 samples; no slip_adv.
//  4. err_in=-2000 constant -> slip_adv pulses, strobe interval 31 samples,
//     phase jumps 0 -> 2 on the slip sample.
//  5. Locked loop; one symbol with err_in=600 -> locked drops in that FILTER cycle,
//     re-asserts after 64 further good symbols.
//  6. Deassert enable mid-FILTER, sample_valid every cycle -> next cycle: IDLE, integ=0,
//     cnt=0, no strobe. Re-enable -> strobe after 32 samples. Also: err_in=max positive for
//     10^5 symbols -> integ clamps at 2^23-1 with no sign flip.

Source files
------------

// File: rtl/gardner_symbol_sync_ctrl.sv
// gardner_symbol_sync_ctrl: symbol strobe generation, PI timing loop with one-sample slips, and lock detect for a Gardner TED
module gardner_symbol_sync_ctrl #(
   parameter int WIDTH    = 16,
   parameter int OSR      = 32,
   parameter int ACC_W    = 24,
   parameter int KP_SHIFT = 2,
   parameter int KI_SHIFT = 6,
   parameter int THRESH   = 4096,
   parameter int LOCK_TOL = 512,
   parameter int LOCK_CNT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       sample_valid,
   input  logic signed [WIDTH-1:0]    err_in,
   output logic                       sym_strobe,
   output logic [$clog2(OSR)-1:0]     phase,
   output logic                       slip_adv,
   output logic                       slip_ret,
   output logic                       locked,
   output logic signed [ACC_W-1:0]    integ
);
   localparam int PW  = $clog2(OSR);
   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam logic [PW-1:0] LAST = PW'(OSR - 1);
   localparam logic [LCW-1:0] LC = LCW'(LOCK_CNT);
   localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);
   localparam logic signed [WIDTH-1:0] LT = WIDTH'(LOCK_TOL);
   localparam logic signed [ACC_W+1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+1:0] MINV = -MAXV;

   typedef enum logic [2:0] {IDLE, TRACK, CAPTURE, FILTER, ADJUST} state_t;
   typedef enum logic [1:0] {NONE, RET, ADV} slip_t;

   state_t                    state_q;
   slip_t                     pend_q;
   logic [PW-1:0]             cnt_q;
   logic signed [WIDTH-1:0]   err_q;
   logic signed [ACC_W-1:0]   integ_q, pacc_q, integ_d, pacc_d;
   logic signed [ACC_W+1:0]   isum_d, psum_d;
   logic [LCW-1:0]            good_q, good_d;
   logic                      lock_ok, locked_q, adv_q, ret_q;

   function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W+1:0] v);
      return (v > MAXV) ? MAXV[ACC_W-1:0] : (v < MINV) ? MINV[ACC_W-1:0] : v[ACC_W-1:0];
   endfunction

   assign sym_strobe = sample_valid && cnt_q == LAST && state_q != IDLE;
   assign phase      = cnt_q;
   assign slip_adv   = adv_q;
   assign slip_ret   = ret_q;
   assign locked     = locked_q;
   assign integ      = integ_q;

   // PI filter update with symmetric saturation, and the good-symbol run length for lock
   always_comb begin
      isum_d  = (ACC_W+2)'(integ_q) + (ACC_W+2)'(err_q);
      psum_d  = (ACC_W+2)'(pacc_q) + (ACC_W+2)'(err_q >>> KP_SHIFT) + (ACC_W+2)'(integ_q >>> KI_SHIFT);
      integ_d = sat(isum_d);
      pacc_d  = sat(psum_d);
      lock_ok = err_q < LT && err_q > -LT;
      good_d  = !lock_ok ? '0 : (good_q == LC) ? good_q : good_q + 1'b1;
   end

   // loop FSM, sample counter with slips; disabling returns everything to a clean IDLE
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state_q  <= IDLE;
         pend_q   <= NONE;
         cnt_q    <= '0;
         err_q    <= '0;
         integ_q  <= '0;
         pacc_q   <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         adv_q    <= 1'b0;
         ret_q    <= 1'b0;
      end else begin
         adv_q <= 1'b0;
         ret_q <= 1'b0;
         if (state_q != IDLE && sample_valid) begin
            if (cnt_q == '0 && pend_q == ADV) begin
               cnt_q  <= PW'(2);
               adv_q  <= 1'b1;
               pend_q <= NONE;
            end else if (cnt_q == '0 && pend_q == RET) begin
               ret_q  <= 1'b1;
               pend_q <= NONE;
            end else begin
               cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end
         case (state_q)
            IDLE:    state_q <= TRACK;
            TRACK:   if (sym_strobe) state_q <= CAPTURE;
            CAPTURE: begin
               err_q   <= err_in;
               state_q <= FILTER;
            end
            FILTER: begin
               integ_q  <= integ_d;
               pacc_q   <= pacc_d;
               good_q   <= good_d;
               locked_q <= good_d == LC;
               state_q  <= ADJUST;
            end
            ADJUST: begin
               if (pend_q == NONE && pacc_q >= TH) begin
                  pend_q <= RET;
                  pacc_q <= pacc_q - TH;
               end else if (pend_q == NONE && pacc_q <= -TH) begin
                  pend_q <= ADV;
                  pacc_q <= pacc_q + TH;
               end
               state_q <= TRACK;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
